// File: rtl/script_pkg.sv
// -----------------------------------------------------------------------------
// script_pkg
// Shared definitions for the kitchen script engine: line opcodes, jump
// condition modes, jump signal selects and the sequencer FSM encoding.
// The jump unit imports the same constants so both sides agree on the
// meaning of a line's func / i_sign fields.
// -----------------------------------------------------------------------------
package script_pkg;

   // Line opcodes (byte0[2:0]); 100/101/110 are undefined.
   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_ACT  = 3'b001;
   localparam logic [2:0] OP_JMP  = 3'b010;
   localparam logic [2:0] OP_WAIT = 3'b011;
   localparam logic [2:0] OP_HALT = 3'b111;

   // Jump condition modes (byte0[4:3]).
   localparam logic [1:0] IF_MODE  = 2'b00;
   localparam logic [1:0] IFN_MODE = 2'b01;

   // Jump signal selects (byte0[7:5]).
   localparam logic [2:0] SIG_PLAYER_READY   = 3'd0;
   localparam logic [2:0] SIG_PLAYER_HASITEM = 3'd1;
   localparam logic [2:0] SIG_TARGET_READY   = 3'd2;
   localparam logic [2:0] SIG_TARGET_HASITEM = 3'd3;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FETCH0,
      ST_FETCH1,
      ST_DECODE,
      ST_JMP1,
      ST_JMP2,
      ST_JMPCAP,
      ST_ACT,
      ST_WAIT,
      ST_HALT
   } seq_state_t;

endpackage

// File: rtl/script_wait_counter.sv
// -----------------------------------------------------------------------------
// script_wait_counter
// Loadable down-counter for wait lines. done is high while the count is 1,
// i.e. in the last cycle of the wait.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val (takes priority over dec)
//   load_val  : wait length in cycles
//   dec       : decrement by one (saturates at 0)
//   done      : count == 1
// -----------------------------------------------------------------------------
module script_wait_counter #(
   parameter int WAIT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WAIT_W-1:0] load_val,
   input  logic              dec,
   output logic              done
);

   logic [WAIT_W-1:0] count;

   // NOTE: sequential state is assigned with non-blocking (<=) so every
   // register samples the values from before the clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - WAIT_W'(1);
      end
   end

   assign done = (count == WAIT_W'(1));

endmodule

// File: rtl/script_sequencer.sv
// -----------------------------------------------------------------------------
// script_sequencer
// Program counter and fetch/decode controller of the script engine. Fetches
// 2-byte lines (byte0 at even PC, byte1 at PC+1) from a synchronous ROM,
// then dispatches: jumps to the jump unit, actions to the action executor
// (valid/ready), waits and halts handled locally.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : begin execution at PC 0 (accepted in IDLE/HALT only)
//   rom_addr/data   : script ROM; data arrives one cycle after the address
//   current_pc      : PC of the executing line
//   jump_*          : jump unit request; jump_next_pc is its registered answer
//   act_valid/code  : action request; act_ready completes it
//   busy/halted     : status
//   illegal         : sticky undefined-opcode flag
// -----------------------------------------------------------------------------
module script_sequencer
   import script_pkg::*;
#(
   parameter int PC_W   = 8,
   parameter int WAIT_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic [PC_W-1:0] rom_addr,
   input  logic [7:0]      rom_data,
   output logic [PC_W-1:0] current_pc,
   output logic            jump_en,
   output logic [7:0]      jump_i_num,
   output logic [1:0]      jump_func,
   output logic [2:0]      jump_i_sign,
   input  logic [PC_W-1:0] jump_next_pc,
   output logic            act_valid,
   output logic [15:0]     act_code,
   input  logic            act_ready,
   output logic            busy,
   output logic            halted,
   output logic            illegal
);

   seq_state_t      state, state_nxt;
   logic [PC_W-1:0] pc, pc_nxt, pc_plus2;
   logic [7:0]      line_lo, line_hi;
   logic            lo_we, hi_we;
   logic            ill_set, ill_clr;
   logic            wait_load, wait_dec, wait_done;

   assign pc_plus2 = pc + PC_W'(2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         pc      <= '0;
         line_lo <= '0;
         line_hi <= '0;
         illegal <= 1'b0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (lo_we) line_lo <= rom_data;
         if (hi_we) line_hi <= rom_data;
         if (ill_clr)      illegal <= 1'b0;
         else if (ill_set) illegal <= 1'b1;
      end
   end

   // NOTE: every signal written here gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      lo_we     = 1'b0;
      hi_we     = 1'b0;
      ill_set   = 1'b0;
      ill_clr   = 1'b0;
      wait_load = 1'b0;
      wait_dec  = 1'b0;
      case (state)
         ST_IDLE, ST_HALT: begin
            if (start) begin
               pc_nxt    = '0;
               ill_clr   = 1'b1;
               state_nxt = ST_FETCH0;
            end
         end
         ST_FETCH0: state_nxt = ST_FETCH1;
         ST_FETCH1: begin
            lo_we     = 1'b1;
            state_nxt = ST_DECODE;
         end
         ST_DECODE: begin
            // byte1 is on rom_data right now; dispatch uses it directly.
            hi_we = 1'b1;
            case (line_lo[2:0])
               OP_NOP: begin
                  pc_nxt    = pc_plus2;
                  state_nxt = ST_FETCH0;
               end
               OP_ACT:  state_nxt = ST_ACT;
               OP_JMP:  state_nxt = ST_JMP1;
               OP_HALT: state_nxt = ST_HALT;
               OP_WAIT: begin
                  if (rom_data == 8'd0) begin
                     pc_nxt    = pc_plus2;
                     state_nxt = ST_FETCH0;
                  end else begin
                     wait_load = 1'b1;
                     state_nxt = ST_WAIT;
                  end
               end
               default: begin
                  ill_set   = 1'b1;
                  pc_nxt    = pc_plus2;
                  state_nxt = ST_FETCH0;
               end
            endcase
         end
         ST_JMP1: state_nxt = ST_JMP2;
         ST_JMP2: state_nxt = ST_JMPCAP;
         ST_JMPCAP: begin
            // Jump unit result is valid this cycle only; it reverts after.
            pc_nxt    = jump_next_pc;
            state_nxt = ST_FETCH0;
         end
         ST_ACT: begin
            if (act_ready) begin
               pc_nxt    = pc_plus2;
               state_nxt = ST_FETCH0;
            end
         end
         ST_WAIT: begin
            wait_dec = 1'b1;
            if (wait_done) begin
               pc_nxt    = pc_plus2;
               state_nxt = ST_FETCH0;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   script_wait_counter #(
      .WAIT_W (WAIT_W)
   ) u_wait (
      .clk      (clk),
      .rst      (rst),
      .load     (wait_load),
      .load_val (WAIT_W'(rom_data)),
      .dec      (wait_dec),
      .done     (wait_done)
   );

   assign rom_addr    = (state == ST_FETCH1) ? pc + PC_W'(1) : pc;
   assign current_pc  = pc;
   assign jump_en     = (state == ST_JMP1) || (state == ST_JMP2);
   assign jump_i_num  = line_hi;
   assign jump_func   = line_lo[4:3];
   assign jump_i_sign = line_lo[7:5];
   assign act_valid   = (state == ST_ACT);
   assign act_code    = {line_hi, line_lo};
   assign halted      = (state == ST_HALT);
   assign busy        = (state != ST_IDLE) && (state != ST_HALT);

endmodule

// File: tb/tb_script_sequencer.sv
// -----------------------------------------------------------------------------
// tb_script_sequencer
// Self-checking bench: ROM, jump unit and action executor models around the
// sequencer, a table of short programs, directed multi-cycle sequences and
// random programs checked against a line-level interpreter.
// -----------------------------------------------------------------------------
module tb_script_sequencer;
   import script_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start, act_ready;
   logic [7:0]  rom_addr, rom_data, current_pc, jump_i_num, jump_next_pc;
   logic [1:0]  jump_func;
   logic [2:0]  jump_i_sign;
   logic        jump_en, act_valid, busy, halted, illegal;
   logic [15:0] act_code;

   script_sequencer #(.PC_W(8), .WAIT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start),
      .rom_addr(rom_addr), .rom_data(rom_data), .current_pc(current_pc),
      .jump_en(jump_en), .jump_i_num(jump_i_num), .jump_func(jump_func),
      .jump_i_sign(jump_i_sign), .jump_next_pc(jump_next_pc),
      .act_valid(act_valid), .act_code(act_code), .act_ready(act_ready),
      .busy(busy), .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_chk  = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // ROM: synchronous read, data one cycle after address.
   logic [7:0] rom [256];
   initial rom_data = 8'h00;
   always @(posedge clk) rom_data <= rom[rom_addr];

   // Jump unit: mode 1 always taken, 2 never taken, 0 uses sig[] with func.
   int         jmode = 0;
   logic [3:0] sig = 4'h0;

   function automatic logic jtaken(input logic [1:0] f, input logic [2:0] s);
      if (jmode == 1) return 1'b1;
      if (jmode == 2) return 1'b0;
      return (f == IFN_MODE) ? ~sig[s[1:0]] : sig[s[1:0]];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst)          jump_next_pc <= 8'h00;
      else if (jump_en) jump_next_pc <= jtaken(jump_func, jump_i_sign)
                                        ? current_pc + (jump_i_num << 1)
                                        : current_pc + 8'd2;
      else              jump_next_pc <= 8'h00;
   end

   // Action executor: ready after a delay of act_code[9:8] cycles, or
   // ready_fixed cycles when that is non-negative.
   int          ready_fixed = -1;
   int          act_hold = 0;
   logic [15:0] got_acts [$];

   initial act_ready = 1'b0;
   always @(negedge clk) begin
      if (act_valid) begin
         if (act_hold == ((ready_fixed >= 0) ? ready_fixed : int'(act_code[9:8]))) begin
            act_ready = 1'b1;
            got_acts.push_back(act_code);
         end else begin
            act_ready = 1'b0;
         end
         act_hold++;
      end else begin
         act_ready = 1'b0;
         act_hold  = 0;
      end
   end

   task automatic fill_rom();
      for (int i = 0; i < 256; i++) rom[i] = 8'h07;
   endtask

   task automatic load_line(input int k, input logic [15:0] l);
      rom[2*k]   = l[7:0];
      rom[2*k+1] = l[15:8];
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Start and count cycles until halted (start edge excluded).
   task automatic run_prog(output int n, output int jen);
      pulse_start();
      n = 1; jen = 0;
      while (!halted && n < 2000) begin
         @(posedge clk); #1;
         n++;
         if (jump_en) jen++;
      end
   endtask

   task automatic wait_halt(input string name);
      int n = 0;
      while (!halted && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, 32'(halted), 32'd1);
   endtask

   // Line-level interpreter for random programs.
   logic [15:0] exp_acts [$];

   task automatic model_run(output int cyc, output logic [7:0] fpc,
                            output logic fill, output int njmp);
      logic [7:0] mpc, b0, b1;
      cyc = 0; fpc = 8'h00; fill = 1'b0; njmp = 0; mpc = 8'h00;
      exp_acts.delete();
      for (int it = 0; it < 200; it++) begin
         b0 = rom[mpc];
         b1 = rom[mpc + 8'd1];
         cyc += 3;
         if (b0[2:0] == OP_HALT) break;
         case (b0[2:0])
            OP_NOP:  mpc += 8'd2;
            OP_ACT:  begin cyc += int'(b1[1:0]) + 1; exp_acts.push_back({b1, b0}); mpc += 8'd2; end
            OP_WAIT: begin cyc += int'(b1); mpc += 8'd2; end
            OP_JMP:  begin
               cyc += 3; njmp++;
               mpc = jtaken(b0[4:3], b0[7:5]) ? mpc + (b1 << 1) : mpc + 8'd2;
            end
            default: begin fill = 1'b1; mpc += 8'd2; end
         endcase
      end
      fpc = mpc;
      cyc += 1;
   endtask

   typedef struct {
      logic [15:0] l0;
      logic [15:0] l1;
      int          jm;
      int          cyc;
      logic [7:0]  pc;
      logic        ill;
   } vec_t;

   vec_t vecs[10];

   task automatic jump_case(input int jm, input logic [7:0] exp_addr);
      logic [6:0] en_bits = '0;
      fill_rom();
      load_line(0, 16'h0202);
      jmode = jm;
      pulse_start();
      for (int c = 1; c <= 7; c++) begin
         if (c > 1) begin @(posedge clk); #1; end
         en_bits[c-1] = jump_en;
         if (c == 6) begin
            check("jmp_hold_inum", 32'(jump_i_num), 32'd2);
            check("jmp_hold_pc", 32'(current_pc), 32'd0);
         end
         if (c == 7) check("jmp_next_fetch", 32'(rom_addr), 32'(exp_addr));
      end
      check("jmp_en_pattern", 32'(en_bits), 32'b0011000);
      wait_halt("jmp_halt");
   endtask

   initial begin
      int          n, jen, ecyc, ejmp, nv;
      logic [7:0]  epc, b0, b1;
      logic        eill, stable;

      start = 1'b0;
      rst   = 1'b0;
      fill_rom();
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rom_addr", 32'(rom_addr), 32'd0);
      check("rst_status", {busy, halted, illegal, jump_en, act_valid}, 32'd0);
      check("rst_act_code", 32'(act_code), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Table of short programs.
      vecs[0] = '{16'h0000, 16'h0007, 0,  7, 8'd2, 1'b0}; // nop, halt
      vecs[1] = '{16'h0007, 16'h0000, 0,  4, 8'd0, 1'b0}; // halt first
      vecs[2] = '{16'h0303, 16'h0007, 0, 10, 8'd2, 1'b0}; // wait 3
      vecs[3] = '{16'h0003, 16'h0007, 0,  7, 8'd2, 1'b0}; // wait 0 == nop
      vecs[4] = '{16'h05FB, 16'h0007, 0, 12, 8'd2, 1'b0}; // wait 5, upper bits set
      vecs[5] = '{16'h0004, 16'h0007, 0,  7, 8'd2, 1'b1}; // illegal 100
      vecs[6] = '{16'hABE6, 16'h0007, 0,  7, 8'd2, 1'b1}; // illegal 110
      vecs[7] = '{16'h0202, 16'h0007, 1, 10, 8'd4, 1'b0}; // jump taken
      vecs[8] = '{16'h0202, 16'h0007, 2, 10, 8'd2, 1'b0}; // jump not taken
      vecs[9] = '{16'h1201, 16'h0007, 0, 10, 8'd2, 1'b0}; // action, ready after 2
      for (int v = 0; v < 10; v++) begin
         fill_rom();
         load_line(0, vecs[v].l0);
         load_line(1, vecs[v].l1);
         jmode = vecs[v].jm;
         run_prog(n, jen);
         check($sformatf("vec%0d_cycles", v), 32'(n), 32'(vecs[v].cyc));
         check($sformatf("vec%0d_pc", v), 32'(current_pc), 32'(vecs[v].pc));
         check($sformatf("vec%0d_illegal", v), 32'(illegal), 32'(vecs[v].ill));
         check($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
      end

      // Reset in the middle of FETCH1 of the second line.
      fill_rom();
      load_line(0, 16'h3C04);
      load_line(1, 16'h0000);
      jmode = 0;
      pulse_start();
      repeat (4) begin @(posedge clk); #1; end
      check("pre_rst_addr", 32'(rom_addr), 32'd3);
      check("pre_rst_illegal", 32'(illegal), 32'd1);
      #3 rst = 1'b1;
      #1;
      check("async_rst_addr", 32'(rom_addr), 32'd0);
      check("async_rst_status", {busy, halted, illegal, jump_en, act_valid}, 32'd0);
      check("async_rst_line", {jump_i_num, jump_func, jump_i_sign}, 32'd0);
      check("async_rst_code", 32'(act_code), 32'd0);
      check("async_rst_pc", 32'(current_pc), 32'd0);
      @(posedge clk); #3;
      rst = 1'b0;
      @(posedge clk); #1;
      pulse_start();
      check("restart_addr0", 32'(rom_addr), 32'd0);
      @(posedge clk); #1;
      check("restart_addr1", 32'(rom_addr), 32'd1);
      wait_halt("restart_halt");
      check("restart_illegal", 32'(illegal), 32'd1);

      // Jump handshake.
      jump_case(1, 8'd4);
      jump_case(2, 8'd2);

      // Action handshake with ready held off for 4 cycles.
      fill_rom();
      load_line(0, 16'h1201);
      ready_fixed = 4;
      pulse_start();
      nv = 0; stable = 1'b1; n = 0;
      while (!act_valid && n < 50) begin @(posedge clk); #1; n++; end
      while (act_valid && n < 50) begin
         nv++;
         if (act_code !== 16'h1201) stable = 1'b0;
         @(posedge clk); #1; n++;
      end
      check("act_valid_cycles", 32'(nv), 32'd5);
      check("act_code_stable", 32'(stable), 32'd1);
      check("act_next_fetch", 32'(rom_addr), 32'd2);
      ready_fixed = -1;
      wait_halt("act_halt");

      // Illegal opcode at PC 254 and wrap to 0.
      fill_rom();
      rom[0] = 8'h02; rom[1] = 8'h7F; rom[2] = 8'h07;
      rom[254] = 8'h04; rom[255] = 8'h00;
      jmode = 1;
      pulse_start();
      for (int c = 2; c <= 10; c++) begin
         @(posedge clk); #1;
         if (c == 7) check("wrap_addr254", 32'(rom_addr), 32'd254);
         if (c == 8) check("wrap_addr255", 32'(rom_addr), 32'd255);
         if (c == 9) jmode = 2;
         if (c == 10) begin
            check("wrap_addr0", 32'(rom_addr), 32'd0);
            check("wrap_illegal", 32'(illegal), 32'd1);
         end
      end
      wait_halt("wrap_halt");
      check("wrap_illegal_sticky", 32'(illegal), 32'd1);
      check("wrap_final_pc", 32'(current_pc), 32'd2);
      pulse_start();
      check("start_clears_illegal", 32'(illegal), 32'd0);
      wait_halt("wrap_rerun_halt");

      // Random programs against the line-level interpreter.
      for (int r = 0; r < 20; r++) begin
         fill_rom();
         jmode = 0;
         sig = 4'($urandom);
         for (int k = 0; k < 23; k++) begin
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            case ($urandom_range(0, 4))
               0: b0[2:0] = OP_NOP;
               1: b0[2:0] = OP_ACT;
               2: begin b0[2:0] = OP_WAIT; b1 = 8'($urandom_range(0, 4)); end
               3: begin
                  b0[2:0] = OP_JMP;
                  b0[7]   = 1'b0;
                  b0[4:3] = 2'($urandom_range(0, 1));
                  b1 = 8'($urandom_range(1, (23 - k < 3) ? 23 - k : 3));
               end
               default: b0[2:0] = 3'($urandom_range(4, 6));
            endcase
            rom[2*k]   = b0;
            rom[2*k+1] = b1;
         end
         model_run(ecyc, epc, eill, ejmp);
         got_acts.delete();
         run_prog(n, jen);
         check($sformatf("rnd%0d_cycles", r), 32'(n), 32'(ecyc));
         check($sformatf("rnd%0d_pc", r), 32'(current_pc), 32'(epc));
         check($sformatf("rnd%0d_illegal", r), 32'(illegal), 32'(eill));
         check($sformatf("rnd%0d_jump_en", r), 32'(jen), 32'(2 * ejmp));
         check($sformatf("rnd%0d_nacts", r), 32'(got_acts.size()), 32'(exp_acts.size()));
         for (int i = 0; i < exp_acts.size() && i < got_acts.size(); i++)
            check($sformatf("rnd%0d_act%0d", r, i), 32'(got_acts[i]), 32'(exp_acts[i]));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
